uart_rx_framer: RTL and testbench

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_rx_framer.sv | 121 ++++++++++++
 tb/tb_uart_rx_framer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framer.sv
// 8N1 UART receive framer: synchronizes rx, locates the mid-bit sample points and
// delivers each byte with a one-cycle rxrdy pulse (or frame_err on a bad stop bit).
module uart_rx_framer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rxrdy,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        rx_p0;
    logic        rx_s;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        half_hit;
    logic        full_hit;

    assign half_hit = (timer == HALF_CNT);
    assign full_hit = (timer == FULL_CNT);

    // Synchronizer stage: both flops idle high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx_s) state_nxt = START;
            START:     if (half_hit) state_nxt = rx_s ? IDLE : DATA;
            DATA:      if (full_hit && bit_idx == 3'd7) state_nxt = STOP;
            STOP:      if (full_hit) state_nxt = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Bit timing and framing stage: timer restarts at every sample point
    always_ff @(posedge clk) begin
        if (rst) begin
            timer     <= 16'd0;
            bit_idx   <= 3'd0;
            rx_data   <= 8'h00;
            rxrdy     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rxrdy     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                START: begin
                    if (half_hit) begin
                        timer   <= 16'd0;
                        bit_idx <= 3'd0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DATA: begin
                    if (full_hit) begin
                        timer   <= 16'd0;
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                STOP: begin
                    if (full_hit) begin
                        timer <= 16'd0;
                        if (rx_s) begin
                            rx_data <= shreg;
                            rxrdy   <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: timer <= 16'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && full_hit) shreg[bit_idx] <= rx_s;
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Randomized bench for uart_rx_framer: serial frames are built from their bytes and
// the received stream is compared against a queue of bytes the line should deliver.
`timescale 1ns/1ps
module tb_uart_rx_framer;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rxrdy;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         got_err = 0;
    int         exp_err = 0;
    int         overlap = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx_framer #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rx_data(rx_data), .rxrdy(rxrdy), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rxrdy) got_q.push_back(rx_data);
        if (frame_err) got_err++;
        if (rxrdy && frame_err) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // stop_low = number of bit times the stop bit is held low (0 = good frame)
    task automatic send_byte(input logic [7:0] b, input int stop_low);
        rx = 1'b0;
        cycles(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(C);
        end
        if (stop_low == 0) begin
            rx = 1'b1;
            cycles(C);
            exp_q.push_back(b);
            last_good = b;
        end else begin
            rx = 1'b0;
            cycles(stop_low * C);
            rx = 1'b1;
            exp_err++;
        end
    endtask

    task automatic send_byte_timed(input logic [7:0] b, input real bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = 1'b1;
        #(bit_ns);
        exp_q.push_back(b);
        last_good = b;
        @(negedge clk);
    endtask

    task automatic settle_and_compare(input string tag);
        cycles(3 * C);
        chk({tag, ".count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s.byte%0d", tag, i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        end
        chk({tag, ".frame_err"}, got_err, exp_err);
        chk({tag, ".overlap"}, overlap, 0);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".rx_data"}, rx_data, last_good);
        got_q.delete();
        exp_q.delete();
        got_err = 0;
        exp_err = 0;
        overlap = 0;
    endtask

    initial begin
        cycles(3);
        rst = 1'b0;
        cycles(1);
        chk("reset.rx_data", rx_data, 8'h00);
        chk("reset.rxrdy", rxrdy, 1'b0);
        chk("reset.frame_err", frame_err, 1'b0);
        chk("reset.busy", busy, 1'b0);
        cycles(4);

        send_byte(8'h55, 0);
        settle_and_compare("single55");

        for (int i = 0; i < 12; i++) send_byte(8'(i), 0);
        settle_and_compare("b2b");

        send_byte(8'hA3, 3);
        cycles(5);
        chk("break.waitidle", busy, 1'b0);
        settle_and_compare("break");

        rx = 1'b0;
        cycles(4);
        chk("glitch.busy_in_start", busy, 1'b1);
        rx = 1'b1;
        settle_and_compare("glitch");

        // abort 0xFF inside bit 4 with a reset, then deliver a clean 0x3C
        rx = 1'b0;
        cycles(C);
        rx = 1'b1;
        cycles(4 * C + 8);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        last_good = 8'h00;
        cycles(1);
        chk("abort.rx_data", rx_data, 8'h00);
        chk("abort.busy", busy, 1'b0);
        cycles(3 * C + 8 + C);
        send_byte(8'h3C, 0);
        settle_and_compare("abort");

        send_byte_timed(8'h81, 160.0 * 1.03);
        send_byte_timed(8'h81, 160.0 * 0.97);
        settle_and_compare("jitter");

        for (int f = 0; f < 24; f++) begin
            logic [7:0] b;
            int bad;
            b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
            send_byte(b, bad);
            cycles((bad != 0) ? int'($urandom_range(2, 20)) : int'($urandom_range(0, 20)));
        end
        settle_and_compare("random");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
